fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_prefetch.sv | 93 +++++++++
 tb/tb_fetch_prefetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared defaults for the instruction prefetch slice.
// Parameter defaults live here so every user agrees on them.
package fetch_prefetch_pkg;

    localparam int PC_W_DEF       = 16;
    localparam int INST_W_DEF     = 16;
    localparam int INST_BYTES_DEF = 2;
    localparam int DEPTH_DEF      = 4;
    localparam int RESET_PC_DEF   = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}.
// Synchronous flush wins over push and pop.
import fetch_prefetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = PC_W_DEF + INST_W_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: PC sequencing, read issue and squash
// control in front of a small queue of fetched instructions.
import fetch_prefetch_pkg::*;

module fetch_prefetch #(
    parameter int PC_W       = PC_W_DEF,
    parameter int INST_W     = INST_W_DEF,
    parameter int INST_BYTES = INST_BYTES_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int RESET_PC   = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_ren,
    output logic [PC_W-1:0]   imem_raddr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redir_valid,
    input  logic              redir_taken,
    input  logic [PC_W-1:0]   redir_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
);
    localparam int SH = $clog2(INST_BYTES);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = PC_W + INST_W;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic            infl_q, infl_d;
    logic            redirect, issue, push, pop;
    logic            full, empty;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic [EW-1:0]   head;

    // In-flight read reserves a slot so a stalled consumer cannot overflow.
    assign redirect = redir_valid & redir_taken;
    assign occ      = {1'b0, count} + {{CW{1'b0}}, infl_q};
    assign issue    = ~redirect & ~full & (occ < (CW+1)'(DEPTH));
    assign push     = infl_q & ~redirect;

    assign inst_valid = ~empty & ~redirect;
    assign pop        = inst_valid & inst_ready;
    assign inst_data  = head[INST_W-1:0];
    assign inst_pc    = head[EW-1:INST_W];

    assign imem_ren   = issue;
    assign imem_raddr = pc_q >> SH;

    always_comb begin
        pc_d   = pc_q;
        ipc_d  = ipc_q;
        infl_d = issue;
        if (redirect) begin
            pc_d = redir_target;
        end else if (issue) begin
            pc_d  = pc_q + PC_W'(INST_BYTES);
            ipc_d = pc_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_q   <= PC_W'(RESET_PC);
            ipc_q  <= '0;
            infl_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ipc_q  <= ipc_d;
            infl_q <= infl_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .CW    (CW)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i ({ipc_q, imem_rdata}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a synchronous-read
// instruction memory model returning addr ^ 16'hA5A5.
module tb_fetch_prefetch;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        imem_ren;
    logic [15:0] imem_raddr;
    logic [15:0] imem_rdata = '0;
    logic        redir_valid = 1'b0;
    logic        redir_taken = 1'b0;
    logic [15:0] redir_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;

    int checks = 0;
    int errors = 0;
    int nren;

    fetch_prefetch dut (
        .clock        (clock),
        .resetn       (resetn),
        .imem_ren     (imem_ren),
        .imem_raddr   (imem_raddr),
        .imem_rdata   (imem_rdata),
        .redir_valid  (redir_valid),
        .redir_taken  (redir_taken),
        .redir_target (redir_target),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] fmem(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    always @(posedge clock)
        if (imem_ren) imem_rdata <= fmem(imem_raddr);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // Leaves the bench 2 time units into cycle 0 after reset release.
    task automatic start(input logic rdy);
        resetn       = 1'b0;
        redir_valid  = 1'b0;
        redir_taken  = 1'b0;
        redir_target = '0;
        inst_ready   = rdy;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 resetn = 1'b0;
        #3;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data", 32'(inst_data), 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);

        // streaming with ready held high
        start(1'b1);
        chk("a_ren0", 32'(imem_ren), 32'd1);
        chk("a_addr0", 32'(imem_raddr), 32'd0);
        chk("a_valid0", 32'(inst_valid), 32'd0);
        for (int c = 1; c < 6; c++) begin
            tick;
            chk("a_addr", 32'(imem_raddr), 32'(c));
            if (c >= 2) begin
                chk("a_valid", 32'(inst_valid), 32'd1);
                chk("a_pc", 32'(inst_pc), 32'(2 * (c - 2)));
                chk("a_data", 32'(inst_data),
                    32'(fmem(16'(c - 2))));
            end else begin
                chk("a_valid1", 32'(inst_valid), 32'd0);
            end
        end

        // stalled consumer fills the queue, then drains in order
        start(1'b0);
        nren = 0;
        for (int i = 0; i < 10; i++) begin
            nren += int'(imem_ren);
            tick;
        end
        chk("b_issues", 32'(nren), 32'd4);
        chk("b_ren_full", 32'(imem_ren), 32'd0);
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("b_valid", 32'(inst_valid), 32'd1);
            chk("b_pc", 32'(inst_pc), 32'(2 * k));
            chk("b_data", 32'(inst_data), 32'(fmem(16'(k))));
            tick;
        end

        // taken redirect with 3 queued and 1 in flight
        start(1'b0);
        repeat (4) tick;
        chk("c_pre_valid", 32'(inst_valid), 32'd1);
        redir_valid  = 1'b1;
        redir_taken  = 1'b1;
        redir_target = 16'h0100;
        #1;
        chk("c_valid_now", 32'(inst_valid), 32'd0);
        chk("c_ren_now", 32'(imem_ren), 32'd0);
        tick;
        redir_valid = 1'b0;
        redir_taken = 1'b0;
        #1;
        chk("c_valid1", 32'(inst_valid), 32'd0);
        chk("c_addr1", 32'(imem_raddr), 32'h0080);
        chk("c_ren1", 32'(imem_ren), 32'd1);
        tick;
        chk("c_valid2", 32'(inst_valid), 32'd0);
        chk("c_addr2", 32'(imem_raddr), 32'h0081);
        tick;
        chk("c_valid3", 32'(inst_valid), 32'd1);
        chk("c_pc3", 32'(inst_pc), 32'h0100);
        chk("c_data3", 32'(inst_data), 32'(fmem(16'h0080)));

        // not-taken redirect must not disturb the stream
        start(1'b1);
        tick;
        for (int c = 2; c < 8; c++) begin
            tick;
            redir_valid  = (c == 4);
            redir_taken  = 1'b0;
            redir_target = 16'h0100;
            #1;
            chk("d_valid", 32'(inst_valid), 32'd1);
            chk("d_pc", 32'(inst_pc), 32'(2 * (c - 2)));
            chk("d_addr", 32'(imem_raddr), 32'(c));
        end
        redir_valid = 1'b0;

        // pc wraps past the top of the address space
        start(1'b1);
        redir_valid  = 1'b1;
        redir_taken  = 1'b1;
        redir_target = 16'hFFFE;
        #1;
        chk("e_valid0", 32'(inst_valid), 32'd0);
        tick;
        redir_valid = 1'b0;
        redir_taken = 1'b0;
        #1;
        chk("e_addr1", 32'(imem_raddr), 32'h7FFF);
        tick;
        chk("e_addr2", 32'(imem_raddr), 32'h0000);
        tick;
        chk("e_pc3", 32'(inst_pc), 32'hFFFE);
        chk("e_data3", 32'(inst_data), 32'(fmem(16'h7FFF)));
        tick;
        chk("e_pc4", 32'(inst_pc), 32'h0000);
        chk("e_data4", 32'(inst_data), 32'(fmem(16'h0000)));

        // reset while the queue is full
        start(1'b0);
        repeat (6) tick;
        chk("f_full_valid", 32'(inst_valid), 32'd1);
        chk("f_full_ren", 32'(imem_ren), 32'd0);
        resetn = 1'b0;
        #1;
        chk("f_rst_valid", 32'(inst_valid), 32'd0);
        chk("f_rst_pc", 32'(inst_pc), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        #1;
        chk("f_addr0", 32'(imem_raddr), 32'd0);
        chk("f_ren0", 32'(imem_ren), 32'd1);
        tick;
        tick;
        chk("f_valid2", 32'(inst_valid), 32'd1);
        chk("f_pc2", 32'(inst_pc), 32'd0);
        chk("f_data2", 32'(inst_data), 32'(fmem(16'h0000)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
